// File: rtl/chacha_xor_stream.sv
// Pulls 64-byte ChaCha keystream bursts into a FIFO and XORs them onto a valid/ready byte stream.
// Optional: define XOR_STATS_EN to add the byte_count output (ciphertext handshakes since reset/flush).
module chacha_xor_stream #(
    parameter int unsigned KS_DEPTH    = 128,
    parameter int unsigned BLOCK_BYTES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      blk_ready,
    output logic                      rd_blk,
    input  logic [7:0]                ks_in,
    input  logic                      pt_valid,
    input  logic [7:0]                pt_data,
    output logic                      pt_ready,
    output logic                      ct_valid,
    output logic [7:0]                ct_data,
    input  logic                      ct_ready,
`ifdef XOR_STATS_EN
    output logic [31:0]               byte_count,
`endif
    output logic [$clog2(KS_DEPTH):0] ks_level
);

    localparam int unsigned AW = $clog2(KS_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(KS_DEPTH);
    localparam logic [LW-1:0] BLOCK_L = LW'(BLOCK_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          push;
    logic          pop;

    logic [7:0]    mem_q [KS_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] free_bytes;
    logic          ct_valid_q, ct_valid_d;
    logic [7:0]    ct_data_q, ct_data_d;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state; a flush on the last burst cycle finishes the burst instead of draining
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (blk_ready && !flush && (free_bytes >= BLOCK_L)) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        rd_blk = (state_q == FETCH) && (cnt_q == '0);
        push   = (state_q == FETCH) && !flush;
    end

    // Keystream FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ks_in;
        end
    end

    always_comb begin
        free_bytes = DEPTH_L - level_q;
        pt_ready   = (level_q != '0) && (!ct_valid_q || ct_ready) && !flush;
        pop        = pt_valid && pt_ready;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ct_valid_d = ct_valid_q;
        ct_data_d  = ct_data_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            ct_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (pop) begin
                ct_valid_d = 1'b1;
                ct_data_d  = pt_data ^ mem_q[rd_ptr_q];
            end else if (ct_ready) begin
                ct_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ct_valid_q <= 1'b0;
            ct_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ct_valid_q <= ct_valid_d;
            ct_data_q  <= ct_data_d;
        end
    end

    assign ks_level = level_q;
    assign ct_valid = ct_valid_q;
    assign ct_data  = ct_data_q;

`ifdef XOR_STATS_EN
    logic [31:0] byte_count_q, byte_count_d;

    always_comb begin
        byte_count_d = byte_count_q;
        if (flush) begin
            byte_count_d = '0;
        end else if (ct_valid_q && ct_ready) begin
            byte_count_d = byte_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count_q <= '0;
        end else begin
            byte_count_q <= byte_count_d;
        end
    end

    assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Scoreboard bench for chacha_xor_stream with a behavioural ChaCha core model (ks byte k = A5 ^ k).
// Build with XOR_STATS_EN defined to also exercise the byte_count output.
module tb_chacha_xor_stream;

    localparam int unsigned KS_DEPTH = 128;
    localparam int unsigned LW       = $clog2(KS_DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          flush     = 1'b0;
    logic          blk_ready = 1'b0;
    logic          rd_blk;
    logic [7:0]    ks_in     = 8'hA5;
    logic          pt_valid  = 1'b0;
    logic [7:0]    pt_data   = 8'h00;
    logic          pt_ready;
    logic          ct_valid;
    logic [7:0]    ct_data;
    logic          ct_ready  = 1'b0;
    logic [LW-1:0] ks_level;
`ifdef XOR_STATS_EN
    logic [31:0]   byte_count;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] exp_q[$];
    int         ks_idx = 0;
    int         n_in   = 0;
    int         n_out  = 0;
    int         rd_count = 0;
    bit         prev_pt_hs = 1'b0;

    bit         core_busy = 1'b0;
    int         core_k    = 0;
    int         core_idle = 0;
    logic       rd_seen;

    chacha_xor_stream #(
        .KS_DEPTH    (KS_DEPTH),
        .BLOCK_BYTES (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .blk_ready  (blk_ready),
        .rd_blk     (rd_blk),
        .ks_in      (ks_in),
        .pt_valid   (pt_valid),
        .pt_data    (pt_data),
        .pt_ready   (pt_ready),
        .ct_valid   (ct_valid),
        .ct_data    (ct_data),
        .ct_ready   (ct_ready),
`ifdef XOR_STATS_EN
        .byte_count (byte_count),
`endif
        .ks_level   (ks_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Core model: 64-byte non-stallable burst, byte 0 in the rd_blk cycle, ready after 4 idle cycles
    initial begin
        forever begin
            @(posedge clk);
            rd_seen = rd_blk;
            #1;
            if (rst) begin
                core_busy = 1'b0;
                core_k    = 0;
                core_idle = 0;
                blk_ready = 1'b0;
            end else if (rd_seen) begin
                core_busy = 1'b1;
                core_k    = 1;
                blk_ready = 1'b0;
            end else if (core_busy) begin
                if (core_k == 63) begin
                    core_busy = 1'b0;
                    core_k    = 0;
                    core_idle = 0;
                end else begin
                    core_k++;
                end
            end else if (!blk_ready) begin
                core_idle++;
                if (core_idle >= 4) blk_ready = 1'b1;
            end
            ks_in = 8'hA5 ^ 8'(core_k);
        end
    end

    // Scoreboard: expected ct pushed on pt handshake, popped on ct handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_pt_hs) check("ct_latency", {31'd0, ct_valid}, 32'd1);
            if (ct_valid && ct_ready) begin
                if (exp_q.size() == 0) check("ct_unexpected", 32'd1, 32'd0);
                else check("ct_data", {24'd0, ct_data}, {24'd0, exp_q.pop_front()});
                n_out++;
            end
            prev_pt_hs = pt_valid && pt_ready;
            if (prev_pt_hs) begin
                exp_q.push_back(pt_data ^ 8'hA5 ^ 8'(ks_idx % 64));
                ks_idx++;
                n_in++;
            end
            if (flush) begin
                n_in       = n_in - exp_q.size();
                exp_q.delete();
                ks_idx     = 0;
                prev_pt_hs = 1'b0;
            end
            if (rd_blk) rd_count++;
        end
    end

    task automatic send(input logic [7:0] d);
        bit got;
        got      = 1'b0;
        pt_valid = 1'b1;
        pt_data  = d;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (pt_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("pt_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        pt_valid = 1'b0;
    endtask

    task automatic wait_rd(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (rd_blk) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rd_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        bit         flag;
        int         t0;
        int         t1;
        int         rc;
        int         guard;
        logic [7:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rd_blk",   {31'd0, rd_blk},   32'd0);
        check("rst_pt_ready", {31'd0, pt_ready}, 32'd0);
        check("rst_ct_valid", {31'd0, ct_valid}, 32'd0);
        check("rst_ct_data",  {24'd0, ct_data},  32'd0);
        check("rst_ks_level", 32'(ks_level),     32'd0);
`ifdef XOR_STATS_EN
        check("rst_byte_count", byte_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two bursts fill the FIFO, then no third request
        wait_rd(50, ok);
        t0 = cyc;
        @(negedge clk);
        check("rd_pulse_width", {31'd0, rd_blk}, 32'd0);
        repeat (63) @(negedge clk);
        check("level_one_block", 32'(ks_level), 32'd64);
        wait_rd(50, ok);
        t1 = cyc;
        check("rd_gap_min", {31'd0, (t1 - t0) >= 64}, 32'd1);
        repeat (64) @(negedge clk);
        check("level_two_blocks", 32'(ks_level), 32'd128);
        rc = rd_count;
        repeat (100) @(negedge clk);
        check("no_third_rd", rd_count, rc);
        check("level_full", 32'(ks_level), 32'd128);

        // Full-rate stream 00,01,02..
        @(posedge clk);
        #1;
        ct_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 32; i++) begin
            check("level_dec", 32'(ks_level), 32'(128 - i));
            send(8'(i));
        end
        check("throughput", cyc - t0, 32'd32);
        check("level_after_stream", 32'(ks_level), 32'd96);

        // Downstream stall mid-stream
        fork
            begin
                for (int i = 0; i < 40; i++) send(8'(i * 7 + 3));
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                ct_ready = 1'b0;
                @(negedge clk);
                held = ct_data;
                check("stall_ct_valid", {31'd0, ct_valid}, 32'd1);
                for (int j = 0; j < 10; j++) begin
                    if (j > 0) @(negedge clk);
                    check("stall_pt_ready", {31'd0, pt_ready}, 32'd0);
                    check("stall_ct_data", {24'd0, ct_data}, {24'd0, held});
                end
                @(posedge clk);
                #1;
                ct_ready = 1'b1;
            end
        join

        // Consume until a fresh burst can start, then flush at burst cycle 20
        guard = 0;
        while (guard < 400 && !(!core_busy && ks_level <= 64)) begin
            guard++;
            send(8'($urandom));
        end
        wait_rd(50, ok);
        t0 = cyc;
        repeat (20) @(posedge clk);
        #1;
        flush    = 1'b1;
        pt_valid = 1'b1;
        pt_data  = 8'h5A;
        @(negedge clk);
        check("flush_pt_ready", {31'd0, pt_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        pt_data = 8'h3C;
        @(negedge clk);
        check("flush_level", 32'(ks_level), 32'd0);
        check("flush_ct_valid", {31'd0, ct_valid}, 32'd0);
        flag = 1'b0;
        ok   = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (ks_level != '0 || pt_ready) flag = 1'b1;
            if (rd_blk) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("rd_timeout_flush", 32'd0, 32'd1);
        t1 = cyc;
        check("drain_empty_no_accept", {31'd0, flag}, 32'd0);
        check("rd_after_flush_gap", {31'd0, (t1 - t0) >= 64}, 32'd1);
        @(negedge clk);
        check("pt_ready_first_push", {31'd0, pt_ready}, 32'd1);
        @(posedge clk);
        #1;
        pt_valid = 1'b0;
        @(negedge clk);
        check("ct_after_flush", {24'd0, ct_data}, 32'h99);

        // Random data with random downstream back-pressure
        fork
            begin
                for (int i = 0; i < 100; i++) send(8'($urandom));
            end
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1;
                    ct_ready = 1'($urandom_range(0, 1));
                end
                ct_ready = 1'b1;
            end
        join
        ct_ready = 1'b1;

`ifdef XOR_STATS_EN
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 200; i++) send(8'($urandom));
        repeat (3) @(negedge clk);
        check("byte_count_200", byte_count, 32'd200);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("byte_count_flush", byte_count, 32'd0);
`endif

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("in_out_count", n_out, n_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
